// File: rtl/katana_pkg.sv
// Shared constants and state encoding
// for the katana centroid tracker.
package katana_pkg;

  localparam int H_ACTIVE_C = 1024;
  localparam int V_ACTIVE_C = 768;
  localparam int SUM_W      = 30;
  localparam int CNT_W      = 20;
  localparam int HW         = 11;
  localparam int VW         = 10;

  localparam logic [HW-1:0] X_RST =
    HW'(H_ACTIVE_C / 2);
  localparam logic [VW-1:0] Y_RST =
    VW'(V_ACTIVE_C / 2);

  typedef enum logic [1:0] {
    IDLE,
    DIV_X,
    DIV_Y,
    UPDATE
  } tracker_state_t;

endpackage

// File: rtl/serial_divider.sv
// Restoring divider, one quotient bit
// per cycle; first bit in the start cycle.
module serial_divider #(
  parameter int N_W = 30,
  parameter int D_W = 20,
  parameter int Q_W = 11
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           start_i,
  input  logic [N_W-1:0] dividend_i,
  input  logic [D_W-1:0] divisor_i,
  output logic           done_o,
  output logic [Q_W-1:0] quotient_o
);

  localparam int CW = $clog2(N_W + 1);

  logic [D_W-1:0] rem_q;
  logic [D_W-1:0] rem_d;
  logic [D_W-1:0] rem_src;
  logic [D_W-1:0] dvs_q;
  logic [D_W-1:0] dvs_src;
  logic [D_W-1:0] dif;
  logic [N_W-1:0] dvd_q;
  logic [N_W-1:0] dvd_d;
  logic [N_W-1:0] dvd_src;
  logic [D_W:0]   shf;
  logic           ge;
  logic [CW-1:0]  cnt_q;
  logic           run_q;
  logic           done_q;

  // One restoring step on either the fresh
  // operands (start) or the running state.
  always_comb begin
    rem_src = start_i ? '0 : rem_q;
    dvd_src = start_i ? dividend_i : dvd_q;
    dvs_src = start_i ? divisor_i : dvs_q;
    shf     = {rem_src, dvd_src[N_W-1]};
    ge      = shf >= {1'b0, dvs_src};
    dif     = shf[D_W-1:0] - dvs_src;
    rem_d   = ge ? dif : shf[D_W-1:0];
    dvd_d   = {dvd_src[N_W-2:0], ge};
  end

  // Iteration counter, shift registers and
  // the done pulse after the last step.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rem_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else if (start_i) begin
      rem_q  <= rem_d;
      dvd_q  <= dvd_d;
      dvs_q  <= divisor_i;
      cnt_q  <= CW'(N_W - 1);
      run_q  <= 1'b1;
      done_q <= 1'b0;
    end else if (run_q) begin
      rem_q <= rem_d;
      dvd_q <= dvd_d;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        run_q  <= 1'b0;
        done_q <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign done_o     = done_q;
  assign quotient_o = dvd_q[Q_W-1:0];

endmodule

// File: rtl/katana_tracker.sv
// Detection-mask centroid: accumulate per
// frame, divide at frame end, pulse result.
module katana_tracker
  import katana_pkg::*;
#(
  parameter int MIN_PIXELS = 64,
  parameter int H_ACTIVE   = H_ACTIVE_C,
  parameter int V_ACTIVE   = V_ACTIVE_C
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic [HW-1:0] hcount_in,
  input  logic [VW-1:0] vcount_in,
  input  logic          mask_in,
  output logic [HW-1:0] katana_x,
  output logic [VW-1:0] katana_y,
  output logic          katana_found_out,
  output logic          katana_valid_out,
  output logic          busy_out,
  output logic          overrun_out
);

  tracker_state_t state_q;
  tracker_state_t state_d;

  logic             pix_hit;
  logic             frame_done;
  logic             found_now;

  logic [SUM_W-1:0] acc_x_q;
  logic [SUM_W-1:0] acc_x_d;
  logic [SUM_W-1:0] acc_y_q;
  logic [SUM_W-1:0] acc_y_d;
  logic [CNT_W-1:0] acc_n_q;
  logic [CNT_W-1:0] acc_n_d;

  logic [SUM_W-1:0] lat_y_q;
  logic [CNT_W-1:0] lat_n_q;
  logic             lat_found_q;

  logic             div_start;
  logic [SUM_W-1:0] div_dvd;
  logic [CNT_W-1:0] div_dvs;
  logic             div_done;
  logic [HW-1:0]    div_quot;
  logic             cap_x;
  logic [HW-1:0]    qx_q;

  logic [HW-1:0]    x_q;
  logic [VW-1:0]    y_q;
  logic             found_q;
  logic             valid_q;
  logic             busy_q;
  logic             ovr_q;

  assign pix_hit = mask_in
    && (hcount_in < HW'(H_ACTIVE))
    && (vcount_in < VW'(V_ACTIVE));

  assign frame_done =
    (hcount_in == HW'(H_ACTIVE))
    && (vcount_in == VW'(V_ACTIVE));

  assign found_now =
    acc_n_q >= CNT_W'(MIN_PIXELS);

  // Accumulate counted pixels; frame end
  // clears, dropping that cycle's pixel.
  always_comb begin
    acc_x_d = acc_x_q;
    acc_y_d = acc_y_q;
    acc_n_d = acc_n_q;
    if (frame_done) begin
      acc_x_d = '0;
      acc_y_d = '0;
      acc_n_d = '0;
    end else if (pix_hit) begin
      acc_x_d = acc_x_q + SUM_W'(hcount_in);
      acc_y_d = acc_y_q + SUM_W'(vcount_in);
      acc_n_d = acc_n_q + CNT_W'(1);
    end
  end

  // Accumulator registers.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      acc_x_q <= '0;
      acc_y_q <= '0;
      acc_n_q <= '0;
    end else begin
      acc_x_q <= acc_x_d;
      acc_y_q <= acc_y_d;
      acc_n_q <= acc_n_d;
    end
  end

  // Latch the finished frame only when idle;
  // the X division takes its sum directly.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      lat_y_q     <= '0;
      lat_n_q     <= '0;
      lat_found_q <= 1'b0;
    end else if (frame_done
                 && state_q == IDLE) begin
      lat_y_q     <= acc_y_q;
      lat_n_q     <= acc_n_q;
      lat_found_q <= found_now;
    end
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (frame_done) begin
          state_d = found_now ? DIV_X
                              : UPDATE;
        end
      end
      DIV_X: begin
        if (div_done) state_d = DIV_Y;
      end
      DIV_Y: begin
        if (div_done) state_d = UPDATE;
      end
      UPDATE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Divider control: X starts on frame end,
  // Y starts as the X quotient is captured.
  always_comb begin
    div_start = 1'b0;
    div_dvd   = acc_x_q;
    div_dvs   = acc_n_q;
    cap_x     = 1'b0;
    unique case (state_q)
      IDLE: begin
        div_start = frame_done && found_now;
      end
      DIV_X: begin
        if (div_done) begin
          div_start = 1'b1;
          div_dvd   = lat_y_q;
          div_dvs   = lat_n_q;
          cap_x     = 1'b1;
        end
      end
      DIV_Y: ;
      UPDATE: ;
      default: ;
    endcase
  end

  serial_divider #(
    .N_W (SUM_W),
    .D_W (CNT_W),
    .Q_W (HW)
  ) u_div (
    .clk_i      (clk_in),
    .rst_ni     (rst_in),
    .start_i    (div_start),
    .dividend_i (div_dvd),
    .divisor_i  (div_dvs),
    .done_o     (div_done),
    .quotient_o (div_quot)
  );

  // Registered outputs, strobe and flags.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      qx_q    <= '0;
      x_q     <= X_RST;
      y_q     <= Y_RST;
      found_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (cap_x) qx_q <= div_quot;
      valid_q <= 1'b0;
      if (state_q == UPDATE) begin
        valid_q <= 1'b1;
        found_q <= lat_found_q;
        if (lat_found_q) begin
          x_q <= qx_q;
          y_q <= div_quot[VW-1:0];
        end
      end
      busy_q <= state_d != IDLE;
      if (frame_done && state_q != IDLE) begin
        ovr_q <= 1'b1;
      end
    end
  end

  assign katana_x         = x_q;
  assign katana_y         = y_q;
  assign katana_found_out = found_q;
  assign katana_valid_out = valid_q;
  assign busy_out         = busy_q;
  assign overrun_out      = ovr_q;

endmodule
